// File: rtl/rt_ibex_pcs_ctrl_if.sv
// ============================================================================
// rt_ibex_pcs_ctrl_if : core/LIFO handshake bundle for the PCS sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rt_ibex_pcs_ctrl_if #(
  parameter int unsigned IrqLevelWidth = 8
);
  logic                     irq_ack_i;
  logic [IrqLevelWidth-1:0] irq_level_i;
  logic                     mret_req_i;
  logic                     mret_ack_o;
  logic                     lifo_push_o;
  logic                     lifo_pop_o;
  logic                     restore_en_o;
  logic                     stall_o;

  // master = core side, slave = the sequencer
  modport master (
    output irq_ack_i, irq_level_i, mret_req_i,
    input  mret_ack_o, lifo_push_o, lifo_pop_o, restore_en_o, stall_o
  );

  modport slave (
    input  irq_ack_i, irq_level_i, mret_req_i,
    output mret_ack_o, lifo_push_o, lifo_pop_o, restore_en_o, stall_o
  );
endinterface

`default_nettype wire

// File: rtl/rt_ibex_pcs_ctrl.sv
// ============================================================================
// rt_ibex_pcs_ctrl : push/pop sequencer for the preemptible context-save LIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module rt_ibex_pcs_ctrl #(
  parameter int unsigned MaxDepth       = 8,
  parameter int unsigned IrqLevelWidth  = 8,
  parameter int unsigned RestoreLatency = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  rt_ibex_pcs_ctrl_if.slave                bus,
  output logic [$clog2(MaxDepth+1)-1:0]    depth_o,
  output logic [IrqLevelWidth-1:0]         curr_level_o,
  output logic                             overflow_o,
  output logic                             underflow_o,
  output logic                             level_err_o
);

  localparam int unsigned DepthW = $clog2(MaxDepth + 1);
  localparam int unsigned IdxW   = (MaxDepth > 1) ? $clog2(MaxDepth) : 1;
  localparam int unsigned CntW   = $clog2(RestoreLatency + 1);

  localparam logic [DepthW-1:0] DepthMax = DepthW'(MaxDepth);
  localparam logic [CntW-1:0]   CntInit  = CntW'(RestoreLatency - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPush    = 3'd1,
    StPop     = 3'd2,
    StPopWait = 3'd3,
    StRestore = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [DepthW-1:0]        depth_q, depth_d;
  logic [IrqLevelWidth-1:0] level_q, level_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic [IrqLevelWidth-1:0] pend_level_q, pend_level_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     level_err_q, level_err_d;
  logic                     uf_ack_q, uf_ack_d;

  logic [IrqLevelWidth-1:0] level_stack_q [MaxDepth];
  logic                     stack_we;
  logic [IdxW-1:0]          stack_widx;
  logic [IdxW-1:0]          stack_ridx;
  logic                     ack_any;
  logic [IrqLevelWidth-1:0] ack_level;

  assign stack_widx = IdxW'(depth_q);
  assign stack_ridx = IdxW'(depth_q - DepthW'(1));

  // A held pending ack is older than one arriving now, so it is served first.
  assign ack_any   = pend_q | bus.irq_ack_i;
  assign ack_level = pend_q ? pend_level_q : bus.irq_level_i;

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_level_d = pend_level_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    level_err_d  = level_err_q;
    uf_ack_d     = 1'b0;
    stack_we     = 1'b0;

    if (bus.irq_ack_i) begin
      pend_d       = 1'b1;
      pend_level_d = bus.irq_level_i;
    end

    unique case (state_q)
      StIdle: begin
        if (ack_any) begin
          pend_d = pend_q & bus.irq_ack_i;
          if (depth_q == DepthMax) begin
            overflow_d = 1'b1;
          end else begin
            if (ack_level <= level_q) level_err_d = 1'b1;
            stack_we = 1'b1;
            depth_d  = depth_q + DepthW'(1);
            level_d  = ack_level;
            state_d  = StPush;
          end
        end else if (bus.mret_req_i && !uf_ack_q) begin
          // uf_ack_q masks the request still held during the ack cycle
          if (depth_q == '0) begin
            underflow_d = 1'b1;
            uf_ack_d    = 1'b1;
          end else begin
            state_d = StPop;
          end
        end
      end
      StPush: state_d = StIdle;
      StPop: begin
        depth_d = depth_q - DepthW'(1);
        level_d = level_stack_q[stack_ridx];
        cnt_d   = CntInit;
        state_d = (RestoreLatency == 1) ? StRestore : StPopWait;
      end
      StPopWait: begin
        if (cnt_q <= CntW'(1)) state_d = StRestore;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StRestore: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      depth_q      <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_level_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      level_err_q  <= 1'b0;
      uf_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_level_q <= pend_level_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      level_err_q  <= level_err_d;
      uf_ack_q     <= uf_ack_d;
    end
  end

  for (genvar g = 0; g < MaxDepth; g++) begin : g_stack
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        level_stack_q[g] <= '0;
      end else if (stack_we && (stack_widx == IdxW'(g))) begin
        level_stack_q[g] <= level_q;
      end
    end
  end

  assign bus.lifo_push_o  = (state_q == StPush);
  assign bus.lifo_pop_o   = (state_q == StPop);
  assign bus.restore_en_o = (state_q == StRestore);
  assign bus.mret_ack_o   = (state_q == StRestore) | uf_ack_q;
  assign bus.stall_o      = (state_q != StIdle);

  assign depth_o      = depth_q;
  assign curr_level_o = level_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
  assign level_err_o  = level_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// ============================================================================
// tb_rt_ibex_pcs_ctrl : scoreboard bench for the PCS sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rt_ibex_pcs_ctrl;
  localparam int MD = 8;
  localparam int LW = 8;
  localparam int RL = 2;
  localparam int EV_PUSH = 0, EV_RESTORE = 1, EV_UACK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rt_ibex_pcs_ctrl_if #(.IrqLevelWidth(LW)) bus ();
  logic [3:0]    depth;
  logic [LW-1:0] curr;
  logic          ovf, udf, lerr;

  rt_ibex_pcs_ctrl #(.MaxDepth(MD), .IrqLevelWidth(LW), .RestoreLatency(RL)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .depth_o(depth), .curr_level_o(curr),
    .overflow_o(ovf), .underflow_o(udf), .level_err_o(lerr)
  );

  typedef struct {
    int kind; int cyc; int depth; int level; int ovf; int udf; int lerr; int pops;
  } exp_t;

  exp_t q[$];
  int   stk[$];
  int   m_curr, m_ovf, m_udf, m_lerr, m_pops;
  int   cyc = 0;
  int   n_cmp = 0, n_fail = 0;
  int   n_pops = 0, last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_ev(input int kind, input int c);
    exp_t e;
    e.kind = kind; e.cyc = c; e.depth = stk.size(); e.level = m_curr;
    e.ovf = m_ovf; e.udf = m_udf; e.lerr = m_lerr; e.pops = m_pops;
    q.push_back(e);
  endfunction

  // Reference behaviour of one ack: push the running level, or record overflow.
  function automatic void model_ack(input int lvl, input int c);
    if (stk.size() == MD) begin
      m_ovf = 1;
    end else begin
      if (lvl <= m_curr) m_lerr = 1;
      stk.push_back(m_curr);
      m_curr = lvl;
      expect_ev(EV_PUSH, c);
    end
  endfunction

  // Monitor: every DUT output event consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lifo_pop_o) begin
        n_pops++;
        last_pop = cyc;
      end
      if (bus.lifo_push_o || bus.restore_en_o || bus.mret_ack_o) begin
        int kind;
        exp_t e;
        kind = bus.lifo_push_o ? EV_PUSH : (bus.restore_en_o ? EV_RESTORE : EV_UACK);
        if (q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
          chk("depth", int'(depth), e.depth);
          chk("curr_level", int'(curr), e.level);
          chk("overflow", int'(ovf), e.ovf);
          chk("underflow", int'(udf), e.udf);
          chk("level_err", int'(lerr), e.lerr);
          chk("pop_count", n_pops, e.pops);
          if (kind == EV_RESTORE) begin
            chk("ack_with_restore", int'(bus.mret_ack_o), 1);
            chk("pop_to_restore", cyc - last_pop, RL);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.stall_o || bus.mret_ack_o) && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("idle_timeout", t, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.irq_ack_i = 1'b0; bus.irq_level_i = '0; bus.mret_req_i = 1'b0;
    q.delete(); stk.delete();
    m_curr = 0; m_ovf = 0; m_udf = 0; m_lerr = 0; m_pops = 0;
    n_pops = 0; last_pop = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_reset_state();
    chk("rst_depth", int'(depth), 0);
    chk("rst_level", int'(curr), 0);
    chk("rst_flags", int'({ovf, udf, lerr}), 0);
    chk("rst_outs", int'({bus.lifo_push_o, bus.lifo_pop_o, bus.restore_en_o,
                          bus.mret_ack_o, bus.stall_o}), 0);
  endtask

  task automatic do_ack(input int lvl);
    wait_idle();
    bus.irq_ack_i = 1'b1;
    bus.irq_level_i = LW'(lvl);
    model_ack(lvl, cyc + 1);
    step();
    bus.irq_ack_i = 1'b0;
    step(); step();
    chk("depth_after_ack", int'(depth), stk.size());
    chk("ovf_after_ack", int'(ovf), m_ovf);
  endtask

  // mret; if chain_dly > 0 an ack of chain_lvl is pulsed mid-sequence.
  task automatic do_mret(input int chain_dly, input int chain_lvl);
    int k, t;
    bit popped;
    wait_idle();
    k = cyc;
    bus.mret_req_i = 1'b1;
    popped = (stk.size() != 0);
    if (!popped) begin
      m_udf = 1;
      expect_ev(EV_UACK, k + 1);
    end else begin
      m_curr = stk.pop_back();
      m_pops++;
      expect_ev(EV_RESTORE, k + 1 + RL);
    end
    if (popped && chain_dly > 0) begin
      repeat (chain_dly) step();
      bus.irq_ack_i = 1'b1;
      bus.irq_level_i = LW'(chain_lvl);
      model_ack(chain_lvl, k + RL + 3);
      step();
      bus.irq_ack_i = 1'b0;
    end
    t = 0;
    @(negedge clk);
    while (!bus.mret_ack_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("mret_ack_timeout", t, 0);
    bus.mret_req_i = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset_state();

    do_ack(3);
    chk("t1_level", int'(curr), 3);

    do_reset();
    do_ack(2); do_ack(5); do_ack(7);
    repeat (3) do_mret(0, 0);
    chk("t2_depth", int'(depth), 0);

    do_reset();
    for (int i = 1; i <= 9; i++) do_ack(i);
    chk("t3_depth", int'(depth), 8);
    chk("t3_ovf", int'(ovf), 1);

    do_reset();
    do_mret(0, 0);
    chk("t4_udf", int'(udf), 1);

    do_reset();
    do_ack(1); do_ack(2);
    do_mret(2, 4);
    wait_idle();
    chk("t5_depth", int'(depth), 2);
    chk("t5_level", int'(curr), 4);

    do_reset();
    do_ack(3); do_ack(1);
    chk("t6_lerr", int'(lerr), 1);
    wait_idle();
    bus.mret_req_i = 1'b1;
    step(); step();
    chk("t6_in_pop_wait", int'(bus.stall_o), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    do_reset();

    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 100; n++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)      do_ack($urandom_range(0, 255));
        else if (r < 8) do_mret(0, 0);
        else            do_mret($urandom_range(1, RL), $urandom_range(0, 255));
      end
      wait_idle();
      step(); step();
      chk("scoreboard_drained", q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
